pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse length in clk cycles, range 1..2^CNT_W-1.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 27000: maximum WAIT_LOCK dwell in cycles (1 ms at 27 MHz).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: number of consecutive locked cycles required before release.
REQ-004 SHALL have parameter CNT_W, default 20: width of the single shared cycle counter.
REQ-005 SHALL have port clk, input, 1 bit: 27 MHz reference clock, the same net as the PLL clkin. It is the only clock.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port pll_lock, input, 1 bit: raw PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port restart_req, input, 1 bit: request to restart the PLL, sampled each cycle.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET input.
REQ-010 SHALL have port core_reset, output, 1 bit: active-high reset for the system clocked by the PLL outputs.
REQ-011 SHALL have port ready, output, 1 bit: PLL locked and stable; core released.
REQ-012 SHALL have port restart_ack, output, 1 bit: one-cycle pulse acknowledging restart_req.
REQ-013 SHALL have port fault, output, 1 bit: retry limit exhausted.
REQ-014 SHALL have port retry_cnt, output, 3 bits: lock timeouts since last RUN; saturates at 7.

Function
REQ-015 SHALL pass pll_lock through a 2-flop synchronizer (lock_s); FSM decisions use lock_s only, so latency is 2 cycles.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN and FAULT. All outputs are registered Moore decodes of the state.
REQ-017 SHALL set output decode as follows:
- pll_reset=1 in PLL_RST and FAULT, else 0.
- core_reset=0 only in RUN.
- ready=1 only in RUN.
- fault=1 only in FAULT.
REQ-018 PLL_RST SHALL increment the counter from 0; at count RST_CYCLES-1 -> WAIT_LOCK with counter=0, so pll_reset is high for exactly RST_CYCLES cycles.
REQ-019 WAIT_LOCK transitions SHALL be:
- lock_s=1 -> STABLE, counter=0.
- Otherwise, at count LOCK_TIMEOUT-1 -> retry_cnt+1 (saturating), then PLL_RST with counter=0.
REQ-020 STABLE transitions SHALL be:
- lock_s=0 -> WAIT_LOCK, counter=0, retry_cnt unchanged.
- At count LOCK_STABLE-1 -> RUN.
REQ-021 On entering RUN, retry_cnt SHALL clear to 0.
REQ-022 In RUN, lock_s=0 SHALL cause -> PLL_RST, counter=0; core_reset=1 and ready=0 from the next cycle.
REQ-023 restart_req=1 in any state except FAULT SHALL cause -> PLL_RST, counter=0, with restart_ack=1 for exactly the following cycle.
REQ-024 restart_req held high SHALL be acknowledged once per cycle it is sampled; the requester deasserts it on ack.
REQ-025 Priority SHALL be reset > restart_req > lock loss > counter terminal count.
REQ-026 The counter SHALL never wrap: every terminal compare forces a reload to 0.

Reset
REQ-027 While reset=1, the block SHALL hold:
- state=PLL_RST, counter=0, synchronizer flops=0.
- pll_reset=1, core_reset=1.
- ready=0, restart_ack=0, fault=0, retry_cnt=0.
REQ-028 Cycle 0 (the first edge with reset=0) SHALL be PLL_RST with counter=0. Asserting reset mid-operation SHALL return to this state on the next edge, regardless of state.

Configuration
REQ-029 With PLL_RETRY_LIMIT_EN defined, the 4th consecutive WAIT_LOCK timeout (retry_cnt becoming 4) SHALL enter FAULT instead of PLL_RST.
REQ-030 FAULT SHALL hold its outputs until restart_req=1, which SHALL clear retry_cnt, pulse restart_ack and enter PLL_RST.
REQ-031 Without PLL_RETRY_LIMIT_EN, FAULT SHALL be unreachable, fault SHALL be constant 0, and timeouts SHALL retry indefinitely with retry_cnt saturating at 7.

Verification
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8.
REQ-032 Lock is high from start, reset released -> pll_reset=1 for cycles 0-3, WAIT_LOCK at 4, STABLE at 5-12, core_reset=0 and ready=1 from cycle 13.
REQ-033 pll_lock is stuck at 0:
- Each WAIT_LOCK dwell is 20 cycles followed by a 4-cycle pll_reset pulse, and retry_cnt steps 1, 2, 3.
- With the macro, the 4th timeout sets fault=1 and pll_reset stays 1.
- Without the macro, retry_cnt saturates at 7 and pulses continue.
REQ-034 pll_lock is low for 1 cycle while STABLE counter=5 -> returns to WAIT_LOCK, retry_cnt unchanged; ready rises 8 cycles after lock_s is re-seen plus 1 WAIT_LOCK cycle.
REQ-035 pll_lock falls in RUN -> core_reset=1 and ready=0 within 3 cycles, then a 4-cycle pll_reset pulse.
REQ-036 restart_req and lock loss occur in the same RUN cycle -> exactly one restart_ack pulse, PLL_RST, retry_cnt=0.
REQ-037 restart_req in FAULT -> fault=0, retry_cnt=0, restart_ack pulse, pll_reset held for 4 more cycles.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, lock qualification and core reset release.
// Optional retry limit enabled with `define PLL_RETRY_LIMIT_EN (otherwise timeouts retry forever).
module pll_lock_supervisor #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 27000,
  parameter int LOCK_STABLE  = 1024,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart_req,
  output logic       pll_reset,
  output logic       core_reset,
  output logic       ready,
  output logic       restart_ack,
  output logic       fault,
  output logic [2:0] retry_cnt
);

  localparam int SYNC_STAGES = 2;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       retry_reg, retry_next;
  logic [2:0]       retry_inc;
  logic             ack_next;

  logic             pll_reset_reg, core_reset_reg, ready_reg, ack_reg, fault_reg;
  logic             pll_reset_next, core_reset_next, ready_next, fault_next;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lock_s;

  // Raw LOCK is asynchronous to clk; only the last stage feeds the FSM.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= pll_lock;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign lock_s    = sync_reg[SYNC_STAGES-1];
  assign retry_inc = (retry_reg == 3'd7) ? 3'd7 : retry_reg + 3'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    ack_next   = 1'b0;

    if (restart_req && (state_reg != FAULT)) begin
      state_next = PLL_RST;
      cnt_next   = '0;
      ack_next   = 1'b1;
    end else begin
      unique case (state_reg)
        PLL_RST: begin
          if (cnt_reg == RST_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            retry_next = retry_inc;
            cnt_next   = '0;
`ifdef PLL_RETRY_LIMIT_EN
            state_next = (retry_inc == 3'd4) ? FAULT : PLL_RST;
`else
            state_next = PLL_RST;
`endif
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
            retry_next = 3'd0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        RUN: begin
          cnt_next = '0;
          if (!lock_s) begin
            state_next = PLL_RST;
          end
        end
        FAULT: begin
          cnt_next = '0;
`ifdef PLL_RETRY_LIMIT_EN
          if (restart_req) begin
            state_next = PLL_RST;
            retry_next = 3'd0;
            ack_next   = 1'b1;
          end
`else
          // Unreachable without the retry limit; recover rather than lock up.
          state_next = PLL_RST;
`endif
        end
        default: begin
          state_next = PLL_RST;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so each register reflects the current state.
  always_comb begin
    pll_reset_next  = (state_next == PLL_RST) || (state_next == FAULT);
    core_reset_next = (state_next != RUN);
    ready_next      = (state_next == RUN);
`ifdef PLL_RETRY_LIMIT_EN
    fault_next      = (state_next == FAULT);
`else
    fault_next      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= PLL_RST;
      cnt_reg        <= '0;
      retry_reg      <= 3'd0;
      pll_reset_reg  <= 1'b1;
      core_reset_reg <= 1'b1;
      ready_reg      <= 1'b0;
      ack_reg        <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      pll_reset_reg  <= pll_reset_next;
      core_reset_reg <= core_reset_next;
      ready_reg      <= ready_next;
      ack_reg        <= ack_next;
      fault_reg      <= fault_next;
    end
  end

  assign pll_reset   = pll_reset_reg;
  assign core_reset  = core_reset_reg;
  assign ready       = ready_reg;
  assign restart_ack = ack_reg;
  assign fault       = fault_reg;
  assign retry_cnt   = retry_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8.
// Observed word packs {pll_reset, core_reset, ready, restart_ack, fault, retry_cnt[2:0]}.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       restart_req;
  logic       pll_reset;
  logic       core_reset;
  logic       ready;
  logic       restart_ack;
  logic       fault;
  logic [2:0] retry_cnt;

  int n_assert;
  int n_fail;

  pll_lock_supervisor #(
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE (8),
    .CNT_W       (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .restart_req(restart_req),
    .pll_reset  (pll_reset),
    .core_reset (core_reset),
    .ready      (ready),
    .restart_ack(restart_ack),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pll_reset, core_reset, ready, restart_ack, fault, retry_cnt};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then compare.
  task automatic cyc_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rc;
    int prev;
    int cur;
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    pll_lock    = 1'b1;
    restart_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_hold", 8'hC0);

    // Lock high from start: PLL_RST 0-3, WAIT_LOCK 4, STABLE 5-12, RUN from 13.
    reset = 1'b0;
    chk("boot_c0", 8'hC0);
    for (int c = 1; c <= 3; c++) cyc_chk("boot_pll_rst", 8'hC0);
    cyc_chk("boot_wait_lock", 8'h40);
    for (int c = 5; c <= 12; c++) cyc_chk("boot_stable", 8'h40);
    cyc_chk("boot_run", 8'h20);
    cyc_chk("boot_run_hold", 8'h20);

    // Lock loss in RUN: two sync cycles, then a 4-cycle PLL reset.
    pll_lock = 1'b0;
    cyc_chk("lockloss_sync1", 8'h20);
    cyc_chk("lockloss_sync2", 8'h20);
    for (int i = 0; i < 4; i++) cyc_chk("lockloss_pll_rst", 8'hC0);

    // Stuck-low lock: 20-cycle WAIT_LOCK dwell then 4-cycle pulse per retry.
`ifdef PLL_RETRY_LIMIT_EN
    for (int r = 1; r <= 3; r++) begin
      for (int i = 0; i < 20; i++) cyc_chk("stuck_wait", 8'h40 | 8'(r - 1));
      for (int i = 0; i < 4; i++) cyc_chk("stuck_pll_rst", 8'hC0 | 8'(r));
    end
    for (int i = 0; i < 20; i++) cyc_chk("stuck_wait_last", 8'h43);
    for (int i = 0; i < 5; i++) cyc_chk("fault_hold", 8'hCC);
    rc = 8'h00;
`else
    for (int r = 1; r <= 8; r++) begin
      prev = r - 1;
      cur  = (r > 7) ? 7 : r;
      for (int i = 0; i < 20; i++) cyc_chk("stuck_wait", 8'h40 | 8'(prev));
      for (int i = 0; i < 4; i++) cyc_chk("stuck_pll_rst", 8'hC0 | 8'(cur));
    end
    rc = 8'h07;
`endif

    // Restart (from FAULT or PLL_RST) with lock restored at the same time.
    restart_req = 1'b1;
    pll_lock    = 1'b1;
    cyc_chk("restart_ack", 8'hD0 | rc);
    restart_req = 1'b0;
    for (int i = 0; i < 3; i++) cyc_chk("restart_pll_rst", 8'hC0 | rc);
    cyc_chk("restart_wait_lock", 8'h40 | rc);
    for (int i = 0; i < 4; i++) cyc_chk("stable_pre_glitch", 8'h40 | rc);
    // One-cycle dropout so lock_s is low while the STABLE count is 5.
    pll_lock = 1'b0;
    cyc_chk("stable_cnt4", 8'h40 | rc);
    pll_lock = 1'b1;
    cyc_chk("stable_cnt5", 8'h40 | rc);
    cyc_chk("glitch_wait_lock", 8'h40 | rc);
    for (int i = 0; i < 8; i++) cyc_chk("stable_again", 8'h40 | rc);
    cyc_chk("run_after_glitch", 8'h20);
    cyc_chk("run_after_glitch_hold", 8'h20);

    // Restart and lock loss seen in the same RUN cycle: a single ack.
    pll_lock = 1'b0;
    cyc_chk("combo_sync1", 8'h20);
    cyc_chk("combo_sync2", 8'h20);
    restart_req = 1'b1;
    cyc_chk("combo_ack", 8'hD0);
    restart_req = 1'b0;
    for (int i = 0; i < 3; i++) cyc_chk("combo_single_ack", 8'hC0);
    cyc_chk("combo_wait_lock", 8'h40);

    // Reset asserted mid-operation returns to PLL_RST on the next edge.
    reset = 1'b1;
    cyc_chk("midreset_enter", 8'hC0);
    cyc_chk("midreset_hold", 8'hC0);
    reset = 1'b0;
    cyc_chk("midreset_release", 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
